// File: rtl/store_sequencer_pkg.sv
// Shared definitions for the store sequencer: store kinds, FSM states and
// the alignment rule that decides whether a request is legal.
package store_sequencer_pkg;

    // store_ctrl encoding as presented by the control unit.
    typedef enum logic [1:0] {
        ST_WORD = 2'b00,
        ST_BYTE = 2'b01,
        ST_HALF = 2'b10,
        ST_ILL  = 2'b11
    } store_ctrl_e;

    // Sequencer states, 3-bit binary.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    // Wide enough for the largest supported read latency (7).
    localparam int CNT_W = 3;

    // A request is rejected for an illegal kind or a misaligned address.
    function automatic logic store_illegal(input logic [1:0] ctrl, input logic [1:0] lane);
        case (ctrl)
            ST_WORD: return lane != 2'b00;
            ST_HALF: return lane[0];
            ST_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: drops the store data into the addressed lane of
// the word read back from memory, leaving every other bit untouched.
module store_merge
    import store_sequencer_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_ctrl,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Start from the read word and overwrite only the selected lane.
    always_comb begin
        merged = rdata;
        case (store_ctrl)
            ST_WORD: merged = wdata;
            ST_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            ST_HALF: begin
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: merged = rdata;
        endcase
    end

endmodule

// File: rtl/store_sequencer.sv
// Multicycle store controller between the control-unit handshake and the
// data memory port. Words are written directly; bytes and halfwords go
// through a read-modify-write of the containing word. Every output is a flop
// loaded from the decode of the next state, so strobes line up with states.
module store_sequencer
    import store_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        store_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e             state_q, state_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [31:0]        merge_rdata;
    logic [31:0]        merged;

    // On the WAIT->WRITE step the word is being captured this very cycle, so
    // merge straight from the memory bus instead of the not-yet-loaded rdata_q.
    assign merge_rdata = (state_q == S_WAIT) ? mem_rdata : rdata_q;

    store_merge u_merge (
        .rdata      (merge_rdata),
        .wdata      (wdata_q),
        .store_ctrl (ctrl_q),
        .lane       (addr_q[1:0]),
        .merged     (merged)
    );

    // Next-state, request capture, latency counter and registered outputs.
    always_comb begin
        // NOTE: every _d starts at its hold value so no branch can infer a latch.
        state_d = state_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctrl_d  = store_ctrl;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (store_illegal(ctrl_q, addr_q[1:0])) state_d = S_ERR;
                else if (ctrl_q == ST_WORD)             state_d = S_WRITE;
                else                                    state_d = S_READ;
            end
            S_READ: begin
                cnt_d   = CNT_W'(MEM_RD_LAT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    rdata_d = mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE) || (state_d == S_ERR);
        err_d       = (state_d == S_ERR);
        mem_rd_d    = (state_d == S_READ);
        mem_wr_d    = (state_d == S_WRITE);
        mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
        mem_wdata_d = (state_d == S_WRITE) ? merged : mem_wdata_q;
    end

    // State and output registers; reset clears everything so an aborted
    // read-modify-write can never emit its write.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctrl_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
